// File: rtl/instruction_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : instruction_encoder_pkg
// Brief  : Shared format codes, RV32 opcodes and encoder FSM states.
// Rev    : 1.0 - initial release
// ============================================================================
package instruction_encoder_pkg;

    localparam logic [2:0] c_fmt_r = 3'd0;
    localparam logic [2:0] c_fmt_i = 3'd1;
    localparam logic [2:0] c_fmt_s = 3'd2;
    localparam logic [2:0] c_fmt_b = 3'd3;
    localparam logic [2:0] c_fmt_u = 3'd4;
    localparam logic [2:0] c_fmt_j = 3'd5;

    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_i    = 7'b0010011;
    localparam logic [6:0] c_op_load = 7'b0000011;
    localparam logic [6:0] c_op_s    = 7'b0100011;
    localparam logic [6:0] c_op_b    = 7'b1100011;
    localparam logic [6:0] c_op_j    = 7'b1101111;
    localparam logic [6:0] c_op_u    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Codes 6 and 7 carry no encoding.
    function automatic logic fmt_illegal(input logic [2:0] fmt);
        return fmt > c_fmt_j;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_encoder_packer.sv
`default_nettype none
// ============================================================================
// Module : instr_field_packer
// Brief  : Combinational RV32 field packer; flags illegal bundles.
// Rev    : 1.0 - initial release
// ============================================================================
module instr_field_packer
    import instruction_encoder_pkg::*;
#(
    parameter int INSTRUCTION_SIZE = 32
) (
    input  logic [2:0]                  i_format,
    input  logic [6:0]                  i_op_code,
    input  logic [4:0]                  i_rd,
    input  logic [4:0]                  i_rs1,
    input  logic [4:0]                  i_rs2,
    input  logic [2:0]                  i_funct3,
    input  logic [6:0]                  i_funct7,
    input  logic [31:0]                 i_imm,
    output logic [INSTRUCTION_SIZE-1:0] o_word,
    output logic                        o_illegal
);

    logic [31:0] w_word;

    always_comb begin
        w_word = 32'd0;
        case (i_format)
            c_fmt_r: w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_op_code};
            c_fmt_i: w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op_code};
            c_fmt_s: w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op_code};
            c_fmt_b: w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                               i_imm[4:1], i_imm[11], i_op_code};
            c_fmt_u: w_word = {i_imm[31:12], i_rd, i_op_code};
            c_fmt_j: w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                               i_rd, i_op_code};
            default: w_word = 32'd0;
        endcase
    end

    // Branch and jump offsets are halfword-granular; bit 0 cannot be encoded.
    assign o_illegal = fmt_illegal(i_format) ||
                       (((i_format == c_fmt_b) || (i_format == c_fmt_j)) && i_imm[0]);

    generate
        if (INSTRUCTION_SIZE == 32) begin : g_exact
            assign o_word = w_word;
        end else begin : g_pad
            assign o_word = {{(INSTRUCTION_SIZE-32){1'b0}}, w_word};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module : instruction_encoder
// Brief  : Accepts field bundles, encodes them and streams words to memory.
// Rev    : 1.0 - initial release
// ============================================================================
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic [WORDSIZE-1:0]         base_addr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_format,
    input  logic [6:0]                  in_op_code,
    input  logic [4:0]                  in_rd,
    input  logic [4:0]                  in_rs1,
    input  logic [4:0]                  in_rs2,
    input  logic [2:0]                  in_funct3,
    input  logic [6:0]                  in_funct7,
    input  logic [WORDSIZE-1:0]         in_immediate,
    output logic                        im_write_en,
    output logic [WORDSIZE-1:0]         im_addr,
    output logic [INSTRUCTION_SIZE-1:0] im_data,
    input  logic                        im_ready,
    output logic                        busy,
    output logic [15:0]                 words_written,
    output logic                        err
);

    state_t                      r_state, w_next_state;
    logic [WORDSIZE-1:0]         r_addr;
    logic [INSTRUCTION_SIZE-1:0] r_data;
    logic [15:0]                 r_count;
    logic                        r_err;
    logic                        r_stop_pend, w_stop_pend_next;
    logic                        w_reload, w_accept, w_reject, w_done;
    logic [INSTRUCTION_SIZE-1:0] w_word;
    logic                        w_illegal;

    instr_field_packer #(
        .INSTRUCTION_SIZE(INSTRUCTION_SIZE)
    ) u_packer (
        .i_format (in_format),
        .i_op_code(in_op_code),
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_imm    (in_immediate[31:0]),
        .o_word   (w_word),
        .o_illegal(w_illegal)
    );

    // Immediate bits above 31 never reach an encoding.
    generate
        if (WORDSIZE > 32) begin : g_imm_hi
            logic w_unused_imm_hi;
            assign w_unused_imm_hi = ^in_immediate[WORDSIZE-1:32];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state     = r_state;
        w_stop_pend_next = r_stop_pend;
        w_reload         = 1'b0;
        w_accept         = 1'b0;
        w_reject         = 1'b0;
        w_done           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_reload     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start) begin
                    w_reload     = 1'b1;
                end else if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (in_valid) begin
                    if (w_illegal) begin
                        w_reject     = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (start) begin
                    w_reload     = 1'b1;
                    w_next_state = ST_RUN;
                end else if (im_ready) begin
                    w_done           = 1'b1;
                    w_stop_pend_next = 1'b0;
                    w_next_state     = (r_stop_pend || stop) ? ST_IDLE : ST_RUN;
                end else if (stop) begin
                    w_stop_pend_next = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_reload) w_stop_pend_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_data      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_stop_pend <= w_stop_pend_next;
            if (w_reload) begin
                r_addr  <= base_addr;
                r_count <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_accept) r_data <= w_word;
                if (w_reject) r_err  <= 1'b1;
                if (w_done) begin
                    r_addr <= r_addr + WORDSIZE'(4);
                    if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                end
            end
        end
    end

    assign in_ready      = (r_state == ST_RUN);
    assign busy          = (r_state != ST_IDLE);
    assign im_write_en   = (r_state == ST_WRITE);
    assign im_addr       = r_addr;
    assign im_data       = r_data;
    assign words_written = r_count;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_instruction_encoder
// Brief  : Directed scoreboard bench for instruction_encoder.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, stop, in_valid, in_ready, im_write_en, im_ready, busy, err;
    logic [63:0] base_addr, in_immediate, im_addr;
    logic [2:0]  in_format, in_funct3;
    logic [6:0]  in_op_code, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] im_data;
    logic [15:0] words_written;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    instruction_encoder #(.WORDSIZE(64), .INSTRUCTION_SIZE(32)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_format(in_format),
        .in_op_code(in_op_code), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_immediate(in_immediate),
        .im_write_en(im_write_en), .im_addr(im_addr), .im_data(im_data),
        .im_ready(im_ready), .busy(busy), .words_written(words_written), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a write completes on the edge after a negedge with en&ready.
    always @(negedge clk) begin
        if (!rst && im_write_en && im_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h want none",
                         im_addr, im_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", im_addr, e.addr);
                check("wr_data", {32'd0, im_data}, {32'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [63:0] base);
        base_addr = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic expect_wr(input logic [63:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [63:0] imm);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        in_format = fmt; in_op_code = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_immediate = imm;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic wait_writes();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) return;
            tick();
        end
        check("write_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [63:0] hold_addr;
        logic [31:0] hold_data;
        rst = 1'b1; start = 1'b0; stop = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_format = '0; in_op_code = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_immediate = '0; im_ready = 1'b1;
        repeat (3) tick();
        check("rst_we",    {63'd0, im_write_en}, 64'd0);
        check("rst_addr",  im_addr, 64'd0);
        check("rst_data",  {32'd0, im_data}, 64'd0);
        check("rst_count", {48'd0, words_written}, 64'd0);
        check("rst_err",   {63'd0, err}, 64'd0);
        check("rst_ready", {63'd0, in_ready}, 64'd0);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        rst = 1'b0;
        tick();

        // R-format
        pulse_start(64'h100);
        check("run_busy",  {63'd0, busy}, 64'd1);
        check("run_ready", {63'd0, in_ready}, 64'd1);
        expect_wr(64'h100, 32'h002081B3);
        send(c_fmt_r, c_op_r, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
        wait_writes();
        check("r_count", {48'd0, words_written}, 64'd1);

        // I then S back to back, after a restart from RUN
        pulse_start(64'h100);
        check("restart_count", {48'd0, words_written}, 64'd0);
        expect_wr(64'h100, 32'h00A00293);
        expect_wr(64'h104, 32'h0020A423);
        send(c_fmt_i, c_op_i, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'd10);
        send(c_fmt_s, c_op_s, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 64'd8);
        wait_writes();
        check("is_count", {48'd0, words_written}, 64'd2);

        // B then U
        expect_wr(64'h108, 32'hFE208EE3);
        expect_wr(64'h10C, 32'h123450B7);
        send(c_fmt_b, c_op_b, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC);
        send(c_fmt_u, c_op_u, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000);
        wait_writes();
        check("bu_count", {48'd0, words_written}, 64'd4);

        // Error bundles are consumed without a write
        send(c_fmt_j, c_op_j, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3);
        check("jodd_err",   {63'd0, err}, 64'd1);
        check("jodd_ready", {63'd0, in_ready}, 64'd1);
        check("jodd_count", {48'd0, words_written}, 64'd4);
        send(3'd7, c_op_r, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
        tick();
        check("fmt7_err",   {63'd0, err}, 64'd1);
        check("fmt7_we",    {63'd0, im_write_en}, 64'd0);
        check("fmt7_count", {48'd0, words_written}, 64'd4);
        expect_wr(64'h110, 32'h008000EF);
        send(c_fmt_j, c_op_j, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd8);
        wait_writes();
        check("j_count",    {48'd0, words_written}, 64'd5);
        check("err_sticky", {63'd0, err}, 64'd1);

        // Backpressure
        im_ready = 1'b0;
        send(c_fmt_r, c_op_r, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
        hold_addr = im_addr;
        hold_data = im_data;
        for (int i = 0; i < 5; i++) begin
            check("bp_we",    {63'd0, im_write_en}, 64'd1);
            check("bp_addr",  im_addr, 64'h114);
            check("bp_data",  {32'd0, im_data}, {32'd0, hold_data});
            check("bp_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        check("bp_hold_addr", im_addr, hold_addr);
        expect_wr(64'h114, 32'h002081B3);
        im_ready = 1'b1;
        wait_writes();
        expect_wr(64'h118, 32'h00A00293);
        send(c_fmt_i, c_op_i, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'd10);
        wait_writes();
        check("bp_count", {48'd0, words_written}, 64'd7);

        // Stop during WRITE lets the write finish, then idles
        im_ready = 1'b0;
        send(c_fmt_r, c_op_r, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stopw_busy", {63'd0, busy}, 64'd1);
        check("stopw_we",   {63'd0, im_write_en}, 64'd1);
        expect_wr(64'h11C, 32'h002081B3);
        im_ready = 1'b1;
        wait_writes();
        check("stop_busy",  {63'd0, busy}, 64'd0);
        check("stop_ready", {63'd0, in_ready}, 64'd0);
        check("stop_count", {48'd0, words_written}, 64'd8);

        // Abort with start during WRITE, unaligned base kept as given
        pulse_start(64'h2000);
        check("start_err_clr", {63'd0, err}, 64'd0);
        im_ready = 1'b0;
        send(c_fmt_r, c_op_r, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
        check("abort_pre_we", {63'd0, im_write_en}, 64'd1);
        pulse_start(64'h3002);
        check("abort_we",    {63'd0, im_write_en}, 64'd0);
        check("abort_addr",  im_addr, 64'h3002);
        check("abort_count", {48'd0, words_written}, 64'd0);
        check("abort_ready", {63'd0, in_ready}, 64'd1);
        im_ready = 1'b1;
        expect_wr(64'h3002, 32'h123450B7);
        send(c_fmt_u, c_op_u, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_1234_5000);
        wait_writes();
        check("unal_count", {48'd0, words_written}, 64'd1);

        // Reset during WRITE
        im_ready = 1'b0;
        send(c_fmt_r, c_op_r, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
        check("rstw_pre_we", {63'd0, im_write_en}, 64'd1);
        rst = 1'b1;
        tick();
        check("rstw_we",    {63'd0, im_write_en}, 64'd0);
        check("rstw_addr",  im_addr, 64'd0);
        check("rstw_data",  {32'd0, im_data}, 64'd0);
        check("rstw_count", {48'd0, words_written}, 64'd0);
        check("rstw_err",   {63'd0, err}, 64'd0);
        check("rstw_ready", {63'd0, in_ready}, 64'd0);
        check("rstw_busy",  {63'd0, busy}, 64'd0);
        rst = 1'b0;
        im_ready = 1'b1;
        repeat (3) tick();
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, data and address width.
REQ-002 SHALL have parameter INSTRUCTION_SIZE, default 32, encoded instruction width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  pulse; begin a load session at base_addr.
REQ-006 SHALL have port stop  in  1  pulse; end the load session.
REQ-007 SHALL have port base_addr  in  WORDSIZE  first instruction-memory address of the session.
REQ-008 SHALL have port in_valid / in_ready  in / out  1 each  field-bundle handshake.
REQ-009 SHALL have port in_format  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-010 SHALL have ports in_op_code (7), in_rd (5), in_rs1 (5), in_rs2 (5), in_funct3 (3) and in_funct7 (7), all inputs carrying instruction fields.
REQ-011 SHALL have port in_immediate  in  WORDSIZE  signed immediate (byte offset for B/J).
REQ-012 SHALL have ports im_write_en (out 1), im_addr (out WORDSIZE), im_data (out INSTRUCTION_SIZE) and im_ready (in 1, memory accepts the write).
REQ-013 SHALL have ports busy (out 1, state is not IDLE), words_written (out 16, session count) and err (out 1, sticky error).

Function
REQ-014 SHALL implement FSM IDLE, RUN and WRITE.
REQ-015 In IDLE, start SHALL do all of the following: load addr=base_addr, clear words_written and err, and go to RUN.
REQ-016 In RUN, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-017 In RUN, in_valid&in_ready SHALL register the encoded word into im_data and go to WRITE on the next cycle; the latency from acceptance to im_write_en is 1 cycle.
REQ-018 In WRITE, im_write_en SHALL be 1, with im_addr/im_data stable until im_ready=1.
REQ-019 On im_ready, the block SHALL do all of the following: addr+=4, words_written+=1 (saturating at 0xFFFF), then return to RUN.
REQ-020 The encoding SHALL be standard RV32:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I: imm[11:0]|rs1|funct3|rd|op.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-021 Upper immediate bits beyond the encoded width SHALL be discarded silently.
REQ-022 An illegal in_format, or in_immediate[0]=1 for B/J, SHALL do all of the following: consume the bundle, set err, write nothing, and stay in RUN.
REQ-023 stop in RUN SHALL go to IDLE; stop in WRITE SHALL let the pending write complete, then go to IDLE.
REQ-024 start in RUN or WRITE SHALL abort any pending write (im_write_en low on the next cycle), reload base_addr, clear the count and err, and go to RUN.
REQ-025 If start and stop are asserted together, start SHALL win.
REQ-026 im_addr SHALL wrap modulo 2^WORDSIZE.
REQ-027 A value of base_addr that is not 4-aligned SHALL be used as given.

Reset
REQ-028 rst SHALL have priority over all inputs and SHALL set state=IDLE and clear every output: im_write_en=0, im_addr=0, im_data=0, words_written=0, err=0, in_ready=0 and busy=0.
REQ-029 rst asserted in WRITE SHALL drop im_write_en on the next cycle with no completion.

Structure
REQ-030 Format codes, opcode constants (R=0110011, I=0010011, load=0000011, S=0100011, B=1100011, J=1101111, U=0110111) and FSM state encodings SHALL reside in the shared package used by control_unit.
REQ-031 Encoding SHALL be a combinational sub-module, instr_field_packer; the FSM, counters and registers SHALL stay in instruction_encoder.

Verification
REQ-032 The bench SHALL cover R-format: start with base_addr=0x100, then send R op=0110011 rd=3 rs1=1 rs2=2 funct3=0 funct7=0 -> im_data=0x002081B3 at im_addr=0x100, and words_written=1.
REQ-033 The bench SHALL cover I and S formats back to back: I addi rd=5 rs1=0 imm=10, then S sw funct3=2 rs1=1 rs2=2 imm=8 -> 0x00A00293 at 0x100, then 0x0020A423 at 0x104.
REQ-034 The bench SHALL cover B and U formats: B beq rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; U lui rd=1 imm=0x12345000 -> 0x123450B7.
REQ-035 The bench SHALL cover error cases: J imm=3 -> err=1, no im_write_en, count unchanged; in_format=7 -> same, with the next legal bundle still written.
REQ-036 The bench SHALL cover backpressure: im_ready held low for 5 cycles -> im_addr/im_data stable and in_ready=0 throughout; on im_ready, addr advances by 4.
REQ-037 The bench SHALL cover abort and reset: start during WRITE -> write dropped and addr=base_addr; rst during WRITE -> all outputs zero next cycle, with state IDLE.
